// File: rtl/uart_pkg.sv
// Shared definitions for the 16x-oversampled UART receive path:
// FSM encoding, framing constants and the baud divider calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_LO  = 7;
  localparam int SAMPLE_MID = 8;
  localparam int SAMPLE_HI  = 9;

  // Clocks per oversample tick, integer floor.
  function automatic int calc_div(input int clk_freq, input int baud_rate,
                                  input int oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock tick every DIV clocks, restartable
// so the tick phase can be aligned to a detected start edge.
module uart_baud_tick #(
  parameter int DIV = 325
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || restart) cnt <= '0;
    else if (tick)        cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_rx_16x.sv
// UART receiver, 8 data bits LSB-first, even parity, one stop bit, with
// 16x oversampling and 2-of-3 majority voting around mid-bit.
module uart_rx_16x #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RXD,
  output logic [7:0] RX_Data,
  output logic       Valid_rx,
  output logic       Parity_error,
  output logic       Stop_error,
  output logic       busy
);
  import uart_pkg::*;

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);

  logic                 rxd_meta, rxd_sync;
  rx_state_t            state, state_next;
  logic                 armed;
  logic                 tick, start_det, commit, maj;
  logic                 s_lo, s_mid;
  logic [3:0]           tick_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_err;

  // Line idles high, so the synchronizer resets to 1 to avoid a fake start.
  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= RXD;
      rxd_sync <= rxd_meta;
    end
  end

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (start_det),
    .tick    (tick)
  );

  assign commit = tick && (tick_cnt == 4'(SAMPLE_HI));
  assign maj    = (s_lo & s_mid) | (s_lo & rxd_sync) | (s_mid & rxd_sync);
  assign busy   = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_det  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (armed && !rxd_sync) begin
          state_next = ST_START;
          start_det  = 1'b1;
        end
      end
      ST_START: begin
        if (commit && maj)                   state_next = ST_IDLE;
        else if (tick && tick_cnt == 4'd15)  state_next = ST_DATA;
      end
      ST_DATA: begin
        if (commit && bit_idx == 3'(DATA_BITS - 1)) state_next = ST_PARITY;
      end
      ST_PARITY: begin
        if (commit) state_next = ST_STOP;
      end
      ST_STOP: begin
        if (commit) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      armed        <= 1'b0;
      tick_cnt     <= '0;
      bit_idx      <= '0;
      s_lo         <= 1'b1;
      s_mid        <= 1'b1;
      shift        <= '0;
      par_err      <= 1'b0;
      RX_Data      <= '0;
      Valid_rx     <= 1'b0;
      Parity_error <= 1'b0;
      Stop_error   <= 1'b0;
    end else begin
      Valid_rx <= 1'b0;

      // Re-arm only after a high level in IDLE, so a held-low break yields one frame.
      if (start_det)                       armed <= 1'b0;
      else if (state == ST_IDLE && rxd_sync) armed <= 1'b1;

      if (start_det)  tick_cnt <= '0;
      else if (tick)  tick_cnt <= tick_cnt + 4'd1;

      if (tick && tick_cnt == 4'(SAMPLE_LO))  s_lo  <= rxd_sync;
      if (tick && tick_cnt == 4'(SAMPLE_MID)) s_mid <= rxd_sync;

      if (start_det) bit_idx <= '0;

      if (commit) begin
        case (state)
          ST_DATA: begin
            shift   <= {maj, shift[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 3'd1;
          end
          ST_PARITY: par_err <= (^shift) ^ maj;
          ST_STOP: begin
            RX_Data      <= shift;
            Parity_error <= par_err;
            Stop_error   <= !maj;
            Valid_rx     <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_16x.sv
// Directed bench for uart_rx_16x using a small divider (10 clocks/tick).
module tb_uart_rx_16x;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int DIV      = 10;
  localparam int BIT      = DIV * 16;
  localparam int LAT      = 170 * DIV + 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       RXD;
  logic [7:0] RX_Data;
  logic       Valid_rx, Parity_error, Stop_error, busy;

  uart_rx_16x #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .RXD          (RXD),
    .RX_Data      (RX_Data),
    .Valid_rx     (Valid_rx),
    .Parity_error (Parity_error),
    .Stop_error   (Stop_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   vcount = 0;
  int   valid_cyc = 0;
  int   wide_cnt = 0;
  logic busy_at_valid = 1'b0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (Valid_rx) begin
      vcount        <= vcount + 1;
      valid_cyc     <= cyc;
      busy_at_valid <= busy;
      if (prev_valid) wide_cnt <= wide_cnt + 1;
    end
    prev_valid <= Valid_rx;
  end

  task automatic idle_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    RXD = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
    RXD = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    RXD   = 1'b1;
    idle_clks(3);
    n_cmp++; if (RX_Data !== 8'h00)    begin n_fail++; $display("FAIL reset_data: got %h expected 00", RX_Data); end
    n_cmp++; if (Valid_rx !== 1'b0)    begin n_fail++; $display("FAIL reset_valid: got %b expected 0", Valid_rx); end
    n_cmp++; if (Parity_error !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b expected 0", Parity_error); end
    n_cmp++; if (Stop_error !== 1'b0)  begin n_fail++; $display("FAIL reset_serr: got %b expected 0", Stop_error); end
    n_cmp++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b0;
    idle_clks(5);
  endtask

  task automatic test_good_frame;
    int v0, fall, lat;
    logic [7:0] d;
    d  = 8'hA5;
    v0 = vcount;
    fall = cyc;
    RXD = 1'b0;
    idle_clks(2);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL good_busy_early: got %b expected 0", busy); end
    idle_clks(1);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL good_busy_rise: got %b expected 1", busy); end
    idle_clks(BIT - 3);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(1'b0);
    send_bit(1'b1);
    RXD = 1'b1;
    idle_clks(2 * BIT);
    lat = valid_cyc - fall;
    n_cmp++; if (vcount - v0 !== 1)     begin n_fail++; $display("FAIL good_count: got %0d expected 1", vcount - v0); end
    n_cmp++; if (RX_Data !== 8'hA5)     begin n_fail++; $display("FAIL good_data: got %h expected a5", RX_Data); end
    n_cmp++; if (Parity_error !== 1'b0) begin n_fail++; $display("FAIL good_perr: got %b expected 0", Parity_error); end
    n_cmp++; if (Stop_error !== 1'b0)   begin n_fail++; $display("FAIL good_serr: got %b expected 0", Stop_error); end
    n_cmp++; if (busy_at_valid !== 1'b0) begin n_fail++; $display("FAIL good_busy_at_valid: got %b expected 0", busy_at_valid); end
    n_cmp++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL good_busy_after: got %b expected 0", busy); end
    n_cmp++; if (lat < LAT - 1 || lat > LAT + 1) begin n_fail++; $display("FAIL good_latency: got %0d expected %0d+-1", lat, LAT); end
  endtask

  task automatic test_parity;
    int v0;
    v0 = vcount;
    send_frame(8'h01, 1'b0, 1'b1);
    idle_clks(2 * BIT);
    n_cmp++; if (vcount - v0 !== 1)     begin n_fail++; $display("FAIL par_count1: got %0d expected 1", vcount - v0); end
    n_cmp++; if (RX_Data !== 8'h01)     begin n_fail++; $display("FAIL par_data1: got %h expected 01", RX_Data); end
    n_cmp++; if (Parity_error !== 1'b1) begin n_fail++; $display("FAIL par_perr1: got %b expected 1", Parity_error); end
    n_cmp++; if (Stop_error !== 1'b0)   begin n_fail++; $display("FAIL par_serr1: got %b expected 0", Stop_error); end
    send_frame(8'h7E, 1'b0, 1'b1);
    idle_clks(2 * BIT);
    n_cmp++; if (vcount - v0 !== 2)     begin n_fail++; $display("FAIL par_count2: got %0d expected 2", vcount - v0); end
    n_cmp++; if (RX_Data !== 8'h7E)     begin n_fail++; $display("FAIL par_data2: got %h expected 7e", RX_Data); end
    n_cmp++; if (Parity_error !== 1'b0) begin n_fail++; $display("FAIL par_perr2: got %b expected 0", Parity_error); end
  endtask

  task automatic test_stop_back_to_back;
    int v0;
    v0 = vcount;
    send_frame(8'h3C, 1'b0, 1'b0);
    idle_clks(8 * DIV);
    n_cmp++; if (vcount - v0 !== 1)     begin n_fail++; $display("FAIL stop_count1: got %0d expected 1", vcount - v0); end
    n_cmp++; if (RX_Data !== 8'h3C)     begin n_fail++; $display("FAIL stop_data1: got %h expected 3c", RX_Data); end
    n_cmp++; if (Stop_error !== 1'b1)   begin n_fail++; $display("FAIL stop_serr1: got %b expected 1", Stop_error); end
    n_cmp++; if (Parity_error !== 1'b0) begin n_fail++; $display("FAIL stop_perr1: got %b expected 0", Parity_error); end
    send_frame(8'h55, 1'b0, 1'b1);
    idle_clks(2 * BIT);
    n_cmp++; if (vcount - v0 !== 2)     begin n_fail++; $display("FAIL b2b_count: got %0d expected 2", vcount - v0); end
    n_cmp++; if (RX_Data !== 8'h55)     begin n_fail++; $display("FAIL b2b_data: got %h expected 55", RX_Data); end
    n_cmp++; if (Stop_error !== 1'b0)   begin n_fail++; $display("FAIL b2b_serr: got %b expected 0", Stop_error); end
    n_cmp++; if (Parity_error !== 1'b0) begin n_fail++; $display("FAIL b2b_perr: got %b expected 0", Parity_error); end
  endtask

  task automatic test_glitch;
    int   v0;
    logic saw;
    v0  = vcount;
    saw = 1'b0;
    RXD = 1'b0;
    idle_clks(3 * DIV);
    RXD = 1'b1;
    for (int i = 0; i < 16 * DIV; i++) begin
      @(negedge clk);
      if (busy) saw = 1'b1;
    end
    n_cmp++; if (saw !== 1'b1)      begin n_fail++; $display("FAIL glitch_busy_seen: got %b expected 1", saw); end
    n_cmp++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL glitch_busy_end: got %b expected 0", busy); end
    n_cmp++; if (vcount - v0 !== 0) begin n_fail++; $display("FAIL glitch_count: got %0d expected 0", vcount - v0); end
  endtask

  task automatic test_reset_midframe;
    int v0;
    v0 = vcount;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    RXD = 1'b1;
    idle_clks(BIT / 2);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
    reset = 1'b1;
    idle_clks(1);
    n_cmp++; if (RX_Data !== 8'h00)     begin n_fail++; $display("FAIL midrst_data: got %h expected 00", RX_Data); end
    n_cmp++; if (Valid_rx !== 1'b0)     begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", Valid_rx); end
    n_cmp++; if (Parity_error !== 1'b0) begin n_fail++; $display("FAIL midrst_perr: got %b expected 0", Parity_error); end
    n_cmp++; if (Stop_error !== 1'b0)   begin n_fail++; $display("FAIL midrst_serr: got %b expected 0", Stop_error); end
    n_cmp++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    reset = 1'b0;
    idle_clks(2 * BIT);
    n_cmp++; if (vcount - v0 !== 0) begin n_fail++; $display("FAIL midrst_count0: got %0d expected 0", vcount - v0); end
    send_frame(8'h81, 1'b0, 1'b1);
    idle_clks(2 * BIT);
    n_cmp++; if (vcount - v0 !== 1)     begin n_fail++; $display("FAIL midrst_count1: got %0d expected 1", vcount - v0); end
    n_cmp++; if (RX_Data !== 8'h81)     begin n_fail++; $display("FAIL midrst_data81: got %h expected 81", RX_Data); end
    n_cmp++; if (Parity_error !== 1'b0) begin n_fail++; $display("FAIL midrst_perr81: got %b expected 0", Parity_error); end
    n_cmp++; if (Stop_error !== 1'b0)   begin n_fail++; $display("FAIL midrst_serr81: got %b expected 0", Stop_error); end
  endtask

  task automatic test_break;
    int v0;
    v0 = vcount;
    RXD = 1'b0;
    idle_clks(20 * BIT);
    n_cmp++; if (vcount - v0 !== 1)     begin n_fail++; $display("FAIL break_count: got %0d expected 1", vcount - v0); end
    n_cmp++; if (RX_Data !== 8'h00)     begin n_fail++; $display("FAIL break_data: got %h expected 00", RX_Data); end
    n_cmp++; if (Stop_error !== 1'b1)   begin n_fail++; $display("FAIL break_serr: got %b expected 1", Stop_error); end
    n_cmp++; if (Parity_error !== 1'b0) begin n_fail++; $display("FAIL break_perr: got %b expected 0", Parity_error); end
    RXD = 1'b1;
    idle_clks(3 * BIT);
    n_cmp++; if (vcount - v0 !== 1) begin n_fail++; $display("FAIL break_release_count: got %0d expected 1", vcount - v0); end
    send_frame(8'hC3, 1'b0, 1'b1);
    idle_clks(2 * BIT);
    n_cmp++; if (vcount - v0 !== 2)   begin n_fail++; $display("FAIL break_next_count: got %0d expected 2", vcount - v0); end
    n_cmp++; if (RX_Data !== 8'hC3)   begin n_fail++; $display("FAIL break_next_data: got %h expected c3", RX_Data); end
    n_cmp++; if (Stop_error !== 1'b0) begin n_fail++; $display("FAIL break_next_serr: got %b expected 0", Stop_error); end
  endtask

  initial begin
    reset = 1'b1;
    RXD   = 1'b1;
    test_reset;
    test_good_frame;
    test_parity;
    test_stop_back_to_back;
    test_glitch;
    test_reset_midframe;
    test_break;
    n_cmp++; if (wide_cnt !== 0) begin n_fail++; $display("FAIL valid_width: got %0d wide pulses expected 0", wide_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
